// File: rtl/robid_alloc.sv
// ROB-id allocator / dispatch admission: in-order ids, occupancy tracking, flush drain.
// Optional full-stall performance counter built when ROBID_ALLOC_PERF_EN is defined.
module robid_alloc #(
  parameter int DEPTH     = 128,
  parameter int FLUSH_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        decode_alloc_req,
  input  logic        rename_stall,
  output logic [7:0]  alloc_robid,
  output logic        alloc_fire,
  output logic        alloc_stall,
  input  logic        rob_retire,
  input  logic        rob_flush,
  output logic [7:0]  free_count,
  output logic        rob_full,
  output logic        rob_empty,
  output logic        underflow,
  output logic [31:0] perf_full_cycles
);

  localparam int PW = $clog2(DEPTH) + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [3:0]    fcnt, fcnt_nxt;
  logic [PW-1:0] head, tail;
  logic [7:0]    count;
  logic          retire_ok;
  logic          uf_evt;

  assign alloc_robid = 8'(tail);
  assign free_count  = 8'(DEPTH) - count;
  assign rob_full    = (count == 8'(DEPTH));
  assign rob_empty   = (count == 8'd0);
  assign alloc_stall = decode_alloc_req & ~alloc_fire;

  always_comb begin
    state_nxt  = state;
    fcnt_nxt   = fcnt;
    alloc_fire = 1'b0;
    retire_ok  = 1'b0;
    uf_evt     = 1'b0;
    if (rob_flush) begin
      state_nxt = FLUSH;
      fcnt_nxt  = 4'(FLUSH_LAT - 1);
    end else begin
      case (state)
        RUN: begin
          alloc_fire = decode_alloc_req & ~rename_stall & ~rob_full;
          retire_ok  = rob_retire & ~rob_empty;
          uf_evt     = rob_retire & rob_empty;
        end
        FLUSH: begin
          if (fcnt == 4'd0) state_nxt = RUN;
          else              fcnt_nxt  = fcnt - 4'd1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Head snaps to tail on flush; tail keeps counting so ids never alias right away.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      fcnt      <= 4'd0;
      head      <= '0;
      tail      <= '0;
      count     <= 8'd0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (rob_flush) begin
        head  <= tail;
        count <= 8'd0;
      end else begin
        if (alloc_fire) tail <= tail + PW'(1);
        if (retire_ok)  head <= head + PW'(1);
        if (alloc_fire & ~retire_ok)      count <= count + 8'd1;
        else if (~alloc_fire & retire_ok) count <= count - 8'd1;
      end
      if (uf_evt) underflow <= 1'b1;
    end
  end

`ifdef ROBID_ALLOC_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst)
      perf_q <= 32'd0;
    else if (decode_alloc_req & rob_full & (state == RUN) & ~rob_flush)
      perf_q <= sat_inc32(perf_q);
  end

  assign perf_full_cycles = perf_q;
`else
  assign perf_full_cycles = 32'd0;
`endif

endmodule

// File: doc/robid_alloc.md
# robid_alloc

ROB-id allocator and dispatch-admission controller in front of the rename stage. It hands decode the next in-order 8-bit ROB id and stalls decode when the ROB is full, when rename is stalled, or while a flush is draining. It frees ids in order as the ROB retires and reclaims all in-flight ids on `rob_flush`. It owns the head/tail pointers and the occupancy count that govern how many instructions can be in flight through rename/dispatch.

## Interface
- `DEPTH`, 128: ROB entries. Power of two, 2..128.
- `FLUSH_LAT`, 2: cycles that admission stays blocked after a flush. Range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `decode_alloc_req`  in  1  decode holds a valid instruction that needs a ROB id this cycle.
- `rename_stall`  in  1  rename cannot accept this cycle.
- `alloc_robid`  out  8  id for the requesting instruction. Equals the tail pointer, zero-extended.
- `alloc_fire`  out  1  an id is consumed this cycle.
- `alloc_stall`  out  1  to decode: hold the instruction and its id.
- `rob_retire`  in  1  ROB retired its oldest entry this cycle.
- `rob_flush`  in  1  full pipeline flush.
- `free_count`  out  8  free entries, 0..DEPTH.
- `rob_full`  out  1  `free_count == 0`.
- `rob_empty`  out  1  `free_count == DEPTH`.
- `underflow`  out  1  sticky error flag: a retire arrived while empty.
- `perf_full_cycles`  out  32  count of cycles where a request was blocked by full (see Configuration).

## Operation
- Pointers `head` and `tail` are each log2(DEPTH)+1 bits wide. The MSB is a wrap bit, and both pointers increment modulo 2·DEPTH.
- `alloc_robid = {0.., tail}`. An id is unique among in-flight entries, and its wrap bit distinguishes generations.
- `count` is in-flight occupancy, 0..DEPTH. `free_count = DEPTH - count`.
- FSM states: RUN, FLUSH. A counter `fcnt` is 4 bits wide.
- In RUN:
  - `alloc_fire = decode_alloc_req & !rename_stall & !rob_full & !rob_flush`.
  - `alloc_stall = decode_alloc_req & !alloc_fire`.
  - On `alloc_fire`, `tail` increments.
  - `retire_ok = rob_retire & !rob_empty & !rob_flush`. On `retire_ok`, `head` increments.
  - Count update: fire only gives +1; retire only gives −1; both together leave count unchanged, even at full or empty. Fire is legal at full when a retire occurs in the same cycle? No: fire requires `!rob_full` from the current count, so there is no bypass.
  - `rob_retire` while empty: the retire is ignored and `underflow` is set (sticky until reset).
- On `rob_flush` (any state; highest priority):
  - Next cycle: `head <= tail`, `count <= 0`, `fcnt <= FLUSH_LAT-1`, state becomes FLUSH.
  - `tail` is NOT reset, so ids stay monotonic and stale tags cannot alias immediately.
  - Same-cycle alloc and retire are dropped. `alloc_fire = 0` in the flush cycle.
- In FLUSH:
  - `alloc_fire = 0` and `alloc_stall = decode_alloc_req`.
  - Retires are ignored, and `underflow` is not set.
  - `fcnt` decrements each cycle. When `fcnt == 0`, the next state is RUN.
  - A new `rob_flush` while in FLUSH reloads `fcnt`.
- Reset (`rst = 0` at an edge) values:
  - head = tail = 0, count = 0, state RUN, `underflow = 0`, perf counter 0.
  - Resulting outputs: `alloc_robid = 0`, `free_count = DEPTH`, `rob_empty = 1`, `rob_full = 0`, `alloc_fire = 0`, `alloc_stall = 0`.
  - Reset overrides flush and any operation in progress.

## Timing
- `alloc_robid`, `alloc_fire`, `alloc_stall` are combinational from the current registers and inputs. Decode samples the id in the same cycle it is offered.
- `free_count`, `rob_full`, `rob_empty` are derived from registers only: there is no input-to-output path.
- Allocation-to-count latency is 1 cycle. The next id appears the cycle after a fire.
- Flush blocks admission for FLUSH_LAT+1 cycles: the flush cycle plus FLUSH_LAT cycles in FLUSH. With FLUSH_LAT = 2, a flush at cycle t allows the first fire at t+3.
- Throughput is one id per cycle.

## Configuration
- `ROBID_ALLOC_PERF_EN` defined:
  - `perf_full_cycles` increments, saturating at 2^32−1, on each cycle with `decode_alloc_req & rob_full & state==RUN & !rob_flush`.
  - Cleared only by reset.
- Not defined: `perf_full_cycles` is constant 0, and no counter register is built.

## Test plan
- Reset, then `decode_alloc_req = 1` for 3 cycles: ids 0, 1, 2 are issued with `alloc_fire = 1`; then `free_count = DEPTH-3` and `rob_empty = 0`.
- DEPTH = 4, continuous requests and no retires:
  - ids 0, 1, 2, 3 are issued, then `rob_full = 1` and `alloc_stall = 1` with `alloc_fire = 0`.
  - One retire leads to exactly one more fire, id 4 (wrap bit set).
- Full and requesting, with `rob_retire = 1`: no fire that cycle; the next cycle fires; `count` stays at DEPTH−1→DEPTH. Simultaneous fire and retire at count 2 leave count at 2.
- Five in flight, `rob_flush` at t with retire and request both high:
  - No fire or retire at t.
  - At t+1: `free_count = DEPTH` and `alloc_robid = 5`.
  - Stalled through t+2; fire at t+3 (FLUSH_LAT = 2).
- `rob_retire` while empty: `underflow` goes to 1 and stays set; `free_count` is unchanged.
- With `ROBID_ALLOC_PERF_EN`: hold the ROB full with requests for 10 cycles, so `perf_full_cycles = 10`. Without the macro it reads 0.
